// File: rtl/legv8_pkg.sv
// Shared LEGv8 decode definitions: instruction format codes, opcode patterns,
// immediate field positions and the stage-A decode helpers.
package legv8_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_D  = 3'd2,
        FMT_B  = 3'd3,
        FMT_CB = 3'd4,
        FMT_IW = 3'd5
    } fmt_t;

    // B format, bits [31:26]
    localparam logic [5:0]  OP_B      = 6'b000101;
    localparam logic [5:0]  OP_BL     = 6'b100101;
    // CB format, bits [31:24]
    localparam logic [7:0]  OP_CBZ    = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ   = 8'b10110101;
    localparam logic [7:0]  OP_BCOND  = 8'b01010100;
    // IW format, bits [31:23]
    localparam logic [8:0]  OP_MOVZ   = 9'b110100101;
    localparam logic [8:0]  OP_MOVK   = 9'b111100101;
    // I format, bits [31:22]
    localparam logic [9:0]  OP_ADDI   = 10'b1001000100;
    localparam logic [9:0]  OP_ADDIS  = 10'b1011000100;
    localparam logic [9:0]  OP_SUBI   = 10'b1101000100;
    localparam logic [9:0]  OP_SUBIS  = 10'b1111000100;
    localparam logic [9:0]  OP_ANDI   = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI   = 10'b1011001000;
    localparam logic [9:0]  OP_EORI   = 10'b1101001000;
    localparam logic [9:0]  OP_ANDIS  = 10'b1111001000;
    // D format, bits [31:21]
    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [10:0] OP_LDURSW = 11'b10111000100;
    localparam logic [10:0] OP_STURW  = 11'b10111000000;
    localparam logic [10:0] OP_LDURH  = 11'b01111000010;
    localparam logic [10:0] OP_STURH  = 11'b01111000000;
    localparam logic [10:0] OP_LDURB  = 11'b00111000010;
    localparam logic [10:0] OP_STURB  = 11'b00111000000;

    localparam int IMM26_LSB = 0;
    localparam int IMM26_W   = 26;
    localparam int IMM19_LSB = 5;
    localparam int IMM19_W   = 19;
    localparam int IMM16_LSB = 5;
    localparam int IMM16_W   = 16;
    localparam int HW_LSB    = 21;
    localparam int HW_W      = 2;
    localparam int IMM12_LSB = 10;
    localparam int IMM12_W   = 12;
    localparam int IMM9_LSB  = 12;
    localparam int IMM9_W    = 9;

    typedef struct packed {
        logic [IMM26_W-1:0] imm26;
        logic [IMM19_W-1:0] imm19;
        logic [IMM16_W-1:0] imm16;
        logic [HW_W-1:0]    hw;
        logic [IMM12_W-1:0] imm12;
        logic [IMM9_W-1:0]  imm9;
    } raw_fields_t;

    // Earlier formats win when opcode prefixes overlap.
    function automatic fmt_t decode_fmt(input logic [31:0] instr);
        if (instr[31:26] inside {OP_B, OP_BL})
            return FMT_B;
        if (instr[31:24] inside {OP_CBZ, OP_CBNZ, OP_BCOND})
            return FMT_CB;
        if (instr[31:23] inside {OP_MOVZ, OP_MOVK})
            return FMT_IW;
        if (instr[31:22] inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                                 OP_ANDI, OP_ORRI, OP_EORI, OP_ANDIS})
            return FMT_I;
        if (instr[31:21] inside {OP_LDUR, OP_STUR, OP_LDURSW, OP_STURW,
                                 OP_LDURH, OP_STURH, OP_LDURB, OP_STURB})
            return FMT_D;
        return FMT_R;
    endfunction

    function automatic raw_fields_t extract_fields(input logic [31:0] instr);
        raw_fields_t f;
        f.imm26 = instr[IMM26_LSB +: IMM26_W];
        f.imm19 = instr[IMM19_LSB +: IMM19_W];
        f.imm16 = instr[IMM16_LSB +: IMM16_W];
        f.hw    = instr[HW_LSB    +: HW_W];
        f.imm12 = instr[IMM12_LSB +: IMM12_W];
        f.imm9  = instr[IMM9_LSB  +: IMM9_W];
        return f;
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream instruction and downstream immediate handshake bundle of the
// immediate decode stage.
interface imm_decode_stage_if
    import legv8_pkg::*;
#(
    parameter int PC_W = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_imm;
    fmt_t            out_fmt;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_instr, out_pc
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_instr, out_pc
    );
endinterface

// File: rtl/imm_decode_stage_extend.sv
// Immediate extension: generic sign/zero extenders and the per-format
// extend-and-shift selector used by stage B.
module sign_extend #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [63:0]      out_o
);
    assign out_o = {{(64-WIDTH){in_i[WIDTH-1]}}, in_i};
endmodule

module zero_extend #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [63:0]      out_o
);
    assign out_o = {{(64-WIDTH){1'b0}}, in_i};
endmodule

module imm_extend
    import legv8_pkg::*;
(
    input  fmt_t        fmt_i,
    input  raw_fields_t fields_i,
    output logic [63:0] imm_o
);
    logic [63:0] se26, se19, ze16, ze12, se9;

    sign_extend #(.WIDTH(IMM26_W)) u_se26 (.in_i(fields_i.imm26), .out_o(se26));
    sign_extend #(.WIDTH(IMM19_W)) u_se19 (.in_i(fields_i.imm19), .out_o(se19));
    zero_extend #(.WIDTH(IMM16_W)) u_ze16 (.in_i(fields_i.imm16), .out_o(ze16));
    zero_extend #(.WIDTH(IMM12_W)) u_ze12 (.in_i(fields_i.imm12), .out_o(ze12));
    sign_extend #(.WIDTH(IMM9_W))  u_se9  (.in_i(fields_i.imm9),  .out_o(se9));

    // Branch offsets are word counts; IW places imm16 in halfword slot hw.
    always_comb begin
        unique case (fmt_i)
            FMT_B:   imm_o = se26 << 2;
            FMT_CB:  imm_o = se19 << 2;
            FMT_IW:  imm_o = ze16 << {fields_i.hw, 4'b0000};
            FMT_I:   imm_o = ze12;
            FMT_D:   imm_o = se9;
            default: imm_o = 64'd0;
        endcase
    end
endmodule

// File: rtl/imm_decode_stage.sv
// Two-stage LEGv8 immediate generator: stage A classifies the format and
// latches raw fields, stage B extends/shifts and drives the result.
module imm_decode_stage
    import legv8_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    imm_decode_stage_if.slave   bus
);
    logic            valid_a_q, valid_a_d;
    fmt_t            fmt_a_q, fmt_a_d;
    raw_fields_t     fields_a_q, fields_a_d;
    logic [31:0]     instr_a_q, instr_a_d;
    logic [PC_W-1:0] pc_a_q, pc_a_d;

    logic            valid_b_q, valid_b_d;
    fmt_t            fmt_b_q, fmt_b_d;
    logic [63:0]     imm_b_q, imm_b_d;
    logic [31:0]     instr_b_q, instr_b_d;
    logic [PC_W-1:0] pc_b_q, pc_b_d;

    logic            adv_a, adv_b;
    logic [63:0]     imm_ext;

    assign adv_b = !valid_b_q || bus.out_ready;
    assign adv_a = !valid_a_q || adv_b;

    imm_extend u_extend (
        .fmt_i    (fmt_a_q),
        .fields_i (fields_a_q),
        .imm_o    (imm_ext)
    );

    always_comb begin
        // NOTE: every next-state starts as its current value so no path leaves a latch.
        valid_a_d  = valid_a_q;
        fmt_a_d    = fmt_a_q;
        fields_a_d = fields_a_q;
        instr_a_d  = instr_a_q;
        pc_a_d     = pc_a_q;
        valid_b_d  = valid_b_q;
        fmt_b_d    = fmt_b_q;
        imm_b_d    = imm_b_q;
        instr_b_d  = instr_b_q;
        pc_b_d     = pc_b_q;

        if (adv_a) begin
            valid_a_d = bus.in_valid;
            if (bus.in_valid) begin
                fmt_a_d    = decode_fmt(bus.in_instr);
                fields_a_d = extract_fields(bus.in_instr);
                instr_a_d  = bus.in_instr;
                pc_a_d     = bus.in_pc;
            end
        end

        if (adv_b) begin
            valid_b_d = valid_a_q;
            if (valid_a_q) begin
                fmt_b_d   = fmt_a_q;
                imm_b_d   = imm_ext;
                instr_b_d = instr_a_q;
                pc_b_d    = pc_a_q;
            end
        end

        // Squash beats acceptance; data may keep stale values under a cleared valid.
        if (flush) begin
            valid_a_d = 1'b0;
            valid_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            valid_a_q  <= 1'b0;
            fmt_a_q    <= FMT_R;
            fields_a_q <= '0;
            instr_a_q  <= '0;
            pc_a_q     <= '0;
            valid_b_q  <= 1'b0;
            fmt_b_q    <= FMT_R;
            imm_b_q    <= '0;
            instr_b_q  <= '0;
            pc_b_q     <= '0;
        end else begin
            valid_a_q  <= valid_a_d;
            fmt_a_q    <= fmt_a_d;
            fields_a_q <= fields_a_d;
            instr_a_q  <= instr_a_d;
            pc_a_q     <= pc_a_d;
            valid_b_q  <= valid_b_d;
            fmt_b_q    <= fmt_b_d;
            imm_b_q    <= imm_b_d;
            instr_b_q  <= instr_b_d;
            pc_b_q     <= pc_b_d;
        end
    end

    assign bus.in_ready  = adv_a;
    assign bus.out_valid = valid_b_q;
    assign bus.out_imm   = imm_b_q;
    assign bus.out_fmt   = fmt_b_q;
    assign bus.out_instr = instr_b_q;
    assign bus.out_pc    = pc_b_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: vector table, directed stall/flush/reset
// sequences and a randomized run against a queue-based reference model.
module tb_imm_decode_stage;
    import legv8_pkg::*;

    logic clk;
    logic reset_n;
    logic flush;
    int   n_checks = 0;
    int   n_pass   = 0;

    imm_decode_stage_if #(.PC_W(64)) bus ();

    imm_decode_stage #(.PC_W(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        fmt_t        fmt;
        logic [63:0] imm;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        fmt_t        fmt;
        logic [63:0] imm;
        int          acc;
    } exp_t;

    vec_t vecs [12];
    exp_t sb [$];

    logic [7:0]  cb_ops [3] = '{8'b10110100, 8'b10110101, 8'b01010100};
    logic [9:0]  i_ops  [8] = '{10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
                                10'b1001001000, 10'b1011001000, 10'b1101001000, 10'b1111001000};
    logic [10:0] d_ops  [8] = '{11'b11111000010, 11'b11111000000, 11'b10111000100, 11'b10111000000,
                                11'b01111000010, 11'b01111000000, 11'b00111000010, 11'b00111000000};

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        else
            n_pass++;
    endtask

    // Inputs change on the falling edge; outputs are read 3 time units before the next rising edge.
    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        #2;
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        if (v >= (64'd1 << (w - 1)))
            return v - (64'd1 << w);
        return v;
    endfunction

    // Reference: value each format's immediate denotes, by plain arithmetic.
    task automatic ref_decode(input logic [31:0] ins, output fmt_t f, output logic [63:0] imm);
        if (ins[31:26] inside {6'b000101, 6'b100101}) begin
            f = FMT_B;  imm = sext(64'(ins[25:0]), 26) * 64'd4;
        end else if (ins[31:24] inside {8'b10110100, 8'b10110101, 8'b01010100}) begin
            f = FMT_CB; imm = sext(64'(ins[23:5]), 19) * 64'd4;
        end else if (ins[31:23] inside {9'b110100101, 9'b111100101}) begin
            f = FMT_IW; imm = 64'(ins[20:5]) * (64'd1 << (16 * int'(ins[22:21])));
        end else if (ins[31:22] inside {10'b1001000100, 10'b1011000100, 10'b1101000100, 10'b1111000100,
                                        10'b1001001000, 10'b1011001000, 10'b1101001000, 10'b1111001000}) begin
            f = FMT_I;  imm = 64'(ins[21:10]);
        end else if (ins[31:21] inside {11'b11111000010, 11'b11111000000, 11'b10111000100, 11'b10111000000,
                                        11'b01111000010, 11'b01111000000, 11'b00111000010, 11'b00111000000}) begin
            f = FMT_D;  imm = sext(64'(ins[20:12]), 9);
        end else begin
            f = FMT_R;  imm = 64'd0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0: return {($urandom_range(0, 1) != 0) ? 6'b100101 : 6'b000101, r[25:0]};
            1: return {cb_ops[$urandom_range(0, 2)], r[23:0]};
            2: return {($urandom_range(0, 1) != 0) ? 9'b111100101 : 9'b110100101, r[22:0]};
            3: return {i_ops[$urandom_range(0, 7)], r[21:0]};
            4: return {d_ops[$urandom_range(0, 7)], r[20:0]};
            default: return r;
        endcase
    endfunction

    // One cycle of the random run: compare handshakes and data against the scoreboard.
    task automatic observe(input int cyc);
        logic       exp_ov;
        exp_t       e;
        fmt_t       f;
        logic [63:0] imm;
        check("rnd_in_ready", 64'(bus.in_ready), 64'(sb.size() < 2 || bus.out_ready));
        exp_ov = (sb.size() > 0) && (cyc - sb[0].acc >= 2);
        check("rnd_out_valid", 64'(bus.out_valid), 64'(exp_ov));
        if (exp_ov && bus.out_ready) begin
            e = sb.pop_front();
            check("rnd_imm",   bus.out_imm,          e.imm);
            check("rnd_fmt",   64'(bus.out_fmt),     64'(e.fmt));
            check("rnd_instr", 64'(bus.out_instr),   64'(e.instr));
            check("rnd_pc",    bus.out_pc,           e.pc);
        end
        if (flush) begin
            sb.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            ref_decode(bus.in_instr, f, imm);
            sb.push_back('{instr: bus.in_instr, pc: bus.in_pc, fmt: f, imm: imm, acc: cyc});
        end
    endtask

    initial begin
        vecs[0]  = '{"addi",      {10'b1001000100, 12'hABC, 5'd2, 5'd1},         FMT_I,  64'h0000_0000_0000_0ABC};
        vecs[1]  = '{"ldur_neg",  {11'b11111000010, 9'b111000111, 2'b00, 10'd0}, FMT_D,  64'hFFFF_FFFF_FFFF_FFC7};
        vecs[2]  = '{"movk_hw3",  {9'b111100101, 2'd3, 16'h1234, 5'd7},          FMT_IW, 64'h1234_0000_0000_0000};
        vecs[3]  = '{"b_ones",    {6'b000101, 26'h3FF_FFFF},                     FMT_B,  64'hFFFF_FFFF_FFFF_FFFC};
        vecs[4]  = '{"cbz_one",   {8'b10110100, 19'h00001, 5'd3},                FMT_CB, 64'h0000_0000_0000_0004};
        vecs[5]  = '{"movz_hw0",  {9'b110100101, 2'd0, 16'hFFFF, 5'd1},          FMT_IW, 64'h0000_0000_0000_FFFF};
        vecs[6]  = '{"bl_maxpos", {6'b100101, 26'h1FF_FFFF},                     FMT_B,  64'h0000_0000_07FF_FFFC};
        vecs[7]  = '{"bcond_min", {8'b01010100, 19'h40000, 5'd1},                FMT_CB, 64'hFFFF_FFFF_FFF0_0000};
        vecs[8]  = '{"sturb_pos", {11'b00111000000, 9'h0FF, 2'b00, 10'h3FF},    FMT_D,  64'h0000_0000_0000_00FF};
        vecs[9]  = '{"add_r",     {11'b10001011000, 5'd3, 6'd0, 5'd2, 5'd1},     FMT_R,  64'h0};
        vecs[10] = '{"andis_max", {10'b1111001000, 12'hFFF, 5'd9, 5'd9},         FMT_I,  64'h0000_0000_0000_0FFF};
        vecs[11] = '{"movz_hw2",  {9'b110100101, 2'd2, 16'hABCD, 5'd0},          FMT_IW, 64'h0000_ABCD_0000_0000};

        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_imm",   bus.out_imm,        64'd0);
        check("rst_out_fmt",   64'(bus.out_fmt),   64'(FMT_R));
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check("rst_out_pc",    bus.out_pc,         64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Vector table: each entry pushed alone, result read after exactly two edges.
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].instr, 64'h1000 + 64'(i * 4), 1'b1, 1'b0);
            drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
            check({vecs[i].name, "_lat1"}, 64'(bus.out_valid), 64'd0);
            drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
            check({vecs[i].name, "_valid"}, 64'(bus.out_valid), 64'd1);
            check({vecs[i].name, "_fmt"},   64'(bus.out_fmt),   64'(vecs[i].fmt));
            check({vecs[i].name, "_imm"},   bus.out_imm,        vecs[i].imm);
            check({vecs[i].name, "_instr"}, 64'(bus.out_instr), 64'(vecs[i].instr));
            check({vecs[i].name, "_pc"},    bus.out_pc,         64'h1000 + 64'(i * 4));
        end
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

        // Backpressure: I0, I1 fill the pipe, I2 waits, then all drain in order.
        drive(1'b1, vecs[0].instr, 64'hA0, 1'b0, 1'b0);
        check("bp_ready0", 64'(bus.in_ready), 64'd1);
        drive(1'b1, vecs[1].instr, 64'hA1, 1'b0, 1'b0);
        check("bp_ready1", 64'(bus.in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, vecs[2].instr, 64'hA2, 1'b0, 1'b0);
            check("bp_stall_ready", 64'(bus.in_ready),  64'd0);
            check("bp_stall_valid", 64'(bus.out_valid), 64'd1);
            check("bp_stall_pc",    bus.out_pc,         64'hA0);
            check("bp_stall_imm",   bus.out_imm,        vecs[0].imm);
        end
        drive(1'b1, vecs[2].instr, 64'hA2, 1'b1, 1'b0);
        check("bp_rel_ready", 64'(bus.in_ready), 64'd1);
        check("bp_out0_pc",   bus.out_pc,        64'hA0);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("bp_out1_valid", 64'(bus.out_valid), 64'd1);
        check("bp_out1_pc",    bus.out_pc,         64'hA1);
        check("bp_out1_imm",   bus.out_imm,        vecs[1].imm);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("bp_out2_valid", 64'(bus.out_valid), 64'd1);
        check("bp_out2_pc",    bus.out_pc,         64'hA2);
        check("bp_out2_imm",   bus.out_imm,        vecs[2].imm);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // Flush with both stages full and a new instruction offered.
        drive(1'b1, vecs[3].instr, 64'hB0, 1'b0, 1'b0);
        drive(1'b1, vecs[4].instr, 64'hB1, 1'b0, 1'b0);
        drive(1'b1, vecs[5].instr, 64'hB2, 1'b0, 1'b1);
        check("fl_full_valid", 64'(bus.out_valid), 64'd1);
        drive(1'b1, vecs[6].instr, 64'hB3, 1'b1, 1'b0);
        check("fl_out_cleared", 64'(bus.out_valid), 64'd0);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("fl_lat1", 64'(bus.out_valid), 64'd0);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("fl_next_valid", 64'(bus.out_valid), 64'd1);
        check("fl_next_pc",    bus.out_pc,         64'hB3);
        check("fl_next_imm",   bus.out_imm,        vecs[6].imm);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("fl_no_dropped", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset between clock edges while the pipe is busy.
        drive(1'b1, vecs[7].instr, 64'hC0, 1'b1, 1'b0);
        drive(1'b1, vecs[8].instr, 64'hC1, 1'b1, 1'b0);
        drive(1'b1, vecs[9].instr, 64'hC2, 1'b1, 1'b0);
        check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(bus.out_valid), 64'd0);
        check("ar_imm",   bus.out_imm,        64'd0);
        check("ar_pc",    bus.out_pc,         64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 reset_n = 1'b1;
        drive(1'b1, vecs[0].instr, 64'hD0, 1'b1, 1'b0);
        check("ar_in_ready",   64'(bus.in_ready),  64'd1);
        check("ar_idle_valid", 64'(bus.out_valid), 64'd0);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("ar_lat1", 64'(bus.out_valid), 64'd0);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        check("ar_addi_valid", 64'(bus.out_valid), 64'd1);
        check("ar_addi_imm",   bus.out_imm,        64'h0ABC);
        check("ar_addi_pc",    bus.out_pc,         64'hD0);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);

        // Randomized traffic with random backpressure and occasional flushes.
        begin
            int cyc;
            cyc = 0;
            for (int n = 0; n < 800; n++) begin
                drive($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
                      $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
                observe(cyc);
                cyc++;
            end
            for (int n = 0; n < 10 && sb.size() > 0; n++) begin
                drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
                observe(cyc);
                cyc++;
            end
            check("rnd_drained", 64'(sb.size()), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Two-stage pipelined immediate generator in the decode path of the LEGv8 CPU.
- Accepts fetched 32-bit instructions with their PC and classifies the instruction format.
- Extracts the immediate field and produces the 64-bit extended, scaled or shifted immediate that the ALU and branch adders consume.
- Uses a valid/ready handshake on both sides, plus a flush input driven by branch resolution.

Parameters:
- PC_W, 64, width of the PC carried alongside each instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all in-flight entries.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_imm  out  64  final immediate.
- out_fmt  out  3  format code (fmt_t).
- out_instr  out  32  instruction passed through.
- out_pc  out  PC_W  PC passed through.

Behaviour:
- **Reset:** reset_n low clears both stage valids immediately. All outputs read 0 during and after reset: out_valid, out_imm, out_fmt (FMT_R), out_instr, out_pc. in_ready is 1 once reset_n is high. Reset mid-operation discards all entries.
- **Stage A (decode):** captures in_instr and in_pc when in_valid && in_ready. It registers fmt and the raw field selects.
- **Stage B (extend):** registers out_imm computed from stage A contents. It drives all out_* ports directly from its registers.
- **Latency:** 2 cycles from acceptance to out_valid with no backpressure.
- **Throughput:** 1 instruction per cycle.
- **Advance rules:**
  - advB = !validB || out_ready.
  - advA = !validA || advB.
  - in_ready = advA (combinational from out_ready; no skid buffer).
  - An entry is consumed when out_valid && out_ready.
- **Stall:** while out_ready=0 with both stages full, all registers hold and outputs stay stable. in_ready=0 in this state.
- **Flush:**
  - Clears validA and validB at the next edge.
  - Has priority over a simultaneous acceptance; the incoming instruction is dropped.
  - An entry handshaked on the same cycle as flush counts as delivered.
  - Data registers need not clear; out_valid=0 the cycle after.
- **Format decode (priority order):**
  - B: [31:26]=000101 (B) or 100101 (BL). imm26 [25:0] sign-extended, then <<2.
  - CB: [31:24]=10110100 (CBZ), 10110101 (CBNZ) or 01010100 (B.cond). imm19 [23:5] sign-extended, then <<2.
  - IW: [31:23]=110100101 (MOVZ) or 111100101 (MOVK). imm16 [20:5] zero-extended, then << (16*hw), with hw = [22:21].
  - I: [31:22] in {1001000100 ADDI, 1011000100 ADDIS, 1101000100 SUBI, 1111000100 SUBIS, 1001001000 ANDI, 1011001000 ORRI, 1101001000 EORI, 1111001000 ANDIS}. imm12 [21:10] zero-extended.
  - D: [31:21] in {11111000010 LDUR, 11111000000 STUR, 10111000100 LDURSW, 10111000000 STURW, 01111000010 LDURH, 01111000000 STURH, 00111000010 LDURB, 00111000000 STURB}. imm9 [20:12] sign-extended.
  - Anything else: FMT_R, imm = 0.
- **Width and arithmetic:**
  - Shifts are logical within 64 bits.
  - No overflow signalling; the IW shift for hw=3 places imm16 in bits [63:48].
- **Stage split:** extension and shift occur in stage B from the stage-A-registered fields. Stage A holds only decode.

Decomposition:
- legv8_pkg:
  - fmt_t enum {FMT_R, FMT_I, FMT_D, FMT_B, FMT_CB, FMT_IW}.
  - Opcode constants for every pattern above.
  - Field bit-position localparams.
- Sub-module imm_extend: combinational; (fmt, raw fields) -> 64-bit imm. Built from the existing ZE/SE extension modules (WIDTH 9/12/16/19/26) plus the shift mux. Instantiated once, in stage B.

Test Plan:
1. **ADDI:** in_instr = {10'b1001000100, 12'hABC, 5'd2, 5'd1}, out_ready=1 -> two cycles later out_valid=1, out_fmt=FMT_I, out_imm=64'h0000_0000_0000_0ABC, out_pc equals in_pc.
2. **LDUR:** imm9 = 9'b111000111 -> out_fmt=FMT_D, out_imm=64'hFFFF_FFFF_FFFF_FFC7. MOVK with imm16=16'h1234, hw=3 -> out_imm=64'h1234_0000_0000_0000.
3. **B with imm26 all ones** -> out_imm=64'hFFFF_FFFF_FFFF_FFFC. CBZ with imm19=19'h00001 -> out_imm=64'h4.
4. **Backpressure:** out_ready=0, push instrs I0, I1, I2 back-to-back -> in_ready=0 once two entries are held, I2 waits and out_* stays stable at I0. Raise out_ready -> I0, I1, I2 delivered in order, one per cycle, none lost or duplicated.
5. **Flush:** both stages full, in_valid=1, flush=1 for one cycle -> next cycle out_valid=0, the incoming instruction is dropped, and the next accepted instruction appears 2 cycles later.
6. **Reset:** assert reset_n low asynchronously mid-stream -> out_valid=0 and out_imm=0 immediately. After release, in_ready=1 and a fresh ADDI completes with 2-cycle latency.
